// File: rtl/arb_merge_pkg.sv
// Shared types and defaults for the two-input 4-phase arbitrated merge.
// Optional source tag output is enabled with ARB_MERGE_SRC_TAG_EN.
package arb_merge_pkg;

    localparam int ARB_WIDTH = 33;
    localparam int ARB_FL    = 2;
    localparam int ARB_BL    = 2;
    localparam int CNT_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        IN_ACK,
        IN_REL,
        FWD,
        OUT_REQ,
        OUT_REL,
        BACK
    } state_e;

    typedef enum logic {
        GNT_R1 = 1'b0,
        GNT_R2 = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter; gnt[0]=R1, gnt[1]=R2.
module rr_arb2
    import arb_merge_pkg::*;
(
    input  logic       req1,
    input  logic       req2,
    input  grant_e     last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            req1 && !req2: gnt = 2'b01;
            !req1 && req2: gnt = 2'b10;
            req1 && req2:
                gnt = (last_grant == GNT_R2) ? 2'b01 : 2'b10;
            default:       gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/arb_merge2_4p.sv
// Two-input arbitrated merge for 4-phase bundled-data channels.
// Define ARB_MERGE_SRC_TAG_EN to add the o_src source tag output.
module arb_merge2_4p
    import arb_merge_pkg::*;
#(
    parameter int WIDTH = ARB_WIDTH,
    parameter int FL    = ARB_FL,
    parameter int BL    = ARB_BL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r1_req,
    input  logic [WIDTH-1:0] r1_data,
    output logic             r1_ack,
    input  logic             r2_req,
    input  logic [WIDTH-1:0] r2_data,
    output logic             r2_ack,
    output logic             o_req,
    output logic [WIDTH-1:0] o_data,
    input  logic             o_ack
`ifdef ARB_MERGE_SRC_TAG_EN
    ,
    output logic             o_src
`endif
);

    localparam logic [CNT_W-1:0] FL_C = CNT_W'(FL);
    localparam logic [CNT_W-1:0] BL_C = CNT_W'(BL);

    state_e           state;
    state_e           state_nxt;
    grant_e           last_grant;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hold;
    logic [1:0]       gnt;
    logic             win_req;
    logic             load_out;

    rr_arb2 u_arb (
        .req1       (r1_req),
        .req2       (r2_req),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    // last_grant doubles as the identity of the token in flight
    assign win_req  = (last_grant == GNT_R1) ? r1_req : r2_req;
    assign load_out = (state_nxt == OUT_REQ) && (state != OUT_REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|gnt) state_nxt = IN_ACK;
            IN_ACK:  if (!win_req) state_nxt = IN_REL;
            IN_REL:  state_nxt = (FL == 0) ? OUT_REQ : FWD;
            FWD:     if (cnt <= 1) state_nxt = OUT_REQ;
            OUT_REQ: if (o_ack) state_nxt = OUT_REL;
            OUT_REL:
                if (!o_ack) state_nxt = (BL == 0) ? IDLE : BACK;
            BACK:    if (cnt <= 1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        r1_ack = (state == IN_ACK) && (last_grant == GNT_R1);
        r2_ack = (state == IN_ACK) && (last_grant == GNT_R2);
        o_req  = (state == OUT_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GNT_R2;
            hold       <= '0;
            cnt        <= '0;
            o_data     <= '0;
        end else begin
            if (state == IDLE && |gnt) begin
                hold       <= gnt[0] ? r1_data : r2_data;
                last_grant <= gnt[0] ? GNT_R1 : GNT_R2;
            end
            unique case (state)
                IN_REL:      cnt <= FL_C;
                FWD, BACK:   if (cnt != 0) cnt <= cnt - 1'b1;
                OUT_REL:     if (!o_ack) cnt <= BL_C;
                default:     cnt <= cnt;
            endcase
            if (load_out) o_data <= hold;
        end
    end

`ifdef ARB_MERGE_SRC_TAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           o_src <= 1'b0;
        else if (load_out) o_src <= (last_grant == GNT_R2);
    end
`endif

endmodule

// File: tb/tb_arb_merge2_4p.sv
// Randomized self-checking bench for arb_merge2_4p against a queue model.
// Checks o_src too when ARB_MERGE_SRC_TAG_EN is defined.
module tb_arb_merge2_4p;

    localparam int W = 33;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         r1_req = 1'b0;
    logic         r2_req = 1'b0;
    logic [W-1:0] r1_data = '0;
    logic [W-1:0] r2_data = '0;
    logic         r1_ack;
    logic         r2_ack;
    logic         o_req;
    logic [W-1:0] o_data;
    logic         o_ack = 1'b0;
`ifdef ARB_MERGE_SRC_TAG_EN
    logic         o_src;
`endif

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    logic [W-1:0] out_log[$];
    int           m_last = 1;
    bit           sink_en = 1'b0;
    int           ack1_seen = 0;
    int           ack2_seen = 0;

    arb_merge2_4p #(.WIDTH(W), .FL(2), .BL(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .r1_req  (r1_req),
        .r1_data (r1_data),
        .r1_ack  (r1_ack),
        .r2_req  (r2_req),
        .r2_data (r2_data),
        .r2_ack  (r2_ack),
        .o_req   (o_req),
        .o_data  (o_data),
        .o_ack   (o_ack)
`ifdef ARB_MERGE_SRC_TAG_EN
        ,
        .o_src   (o_src)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ackof(input int p);
        return (p == 1) ? r1_ack : r2_ack;
    endfunction

    // Reference: both pending -> alternate; otherwise the only one pending
    task automatic take();
        int tot = q1.size() + q2.size();
        int es;
        logic [W-1:0] ed;
        chk("out_expected", 64'(tot != 0), 64'd1);
        out_log.push_back(o_data);
        if (tot != 0) begin
            if (q1.size() != 0 && q2.size() != 0) es = 1 - m_last;
            else es = (q1.size() != 0) ? 0 : 1;
            ed = (es == 0) ? q1.pop_front() : q2.pop_front();
            m_last = es;
            chk("o_data", 64'(o_data), 64'(ed));
`ifdef ARB_MERGE_SRC_TAG_EN
            chk("o_src", 64'(o_src), 64'(es));
`endif
        end
    endtask

    task automatic send(input int p, input logic [W-1:0] d);
        int n = 0;
        if (p == 1) begin
            q1.push_back(d); r1_data = d; r1_req = 1'b1;
        end else begin
            q2.push_back(d); r2_data = d; r2_req = 1'b1;
        end
        while (!ackof(p) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk(p == 1 ? "r1_ack_rise" : "r2_ack_rise", 64'(n >= 300), 64'd0);
        if (p == 1) r1_req = 1'b0;
        else        r2_req = 1'b0;
        n = 0;
        while (ackof(p) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk(p == 1 ? "r1_ack_fall" : "r2_ack_fall", 64'(n >= 300), 64'd0);
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (out_log.size() < n && k < 3000) begin
            @(posedge clk); #1; k++;
        end
        chk("wait_out", 64'(out_log.size() >= n), 64'd1);
        repeat (10) begin @(posedge clk); #1; end
    endtask

    task automatic wait_oreq();
        int k = 0;
        while (!o_req && k < 200) begin
            @(posedge clk); #1; k++;
        end
        chk("wait_oreq", 64'(o_req), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q1.delete(); q2.delete();
        m_last = 1;
        #1;
        chk("rst_o_req", 64'(o_req), 64'd0);
        chk("rst_acks", 64'({r1_ack, r2_ack}), 64'd0);
        chk("rst_o_data", 64'(o_data), 64'd0);
`ifdef ARB_MERGE_SRC_TAG_EN
        chk("rst_o_src", 64'(o_src), 64'd0);
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Protocol monitor: ack exclusivity and output data stability
    initial begin
        logic prev_act = 1'b0;
        logic act;
        logic [W-1:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_act = 1'b0;
            end else begin
                chk("ack_excl", 64'(r1_ack & r2_ack), 64'd0);
                chk("ack_vs_oreq", 64'((r1_ack | r2_ack) & o_req), 64'd0);
                if (r1_ack) ack1_seen++;
                if (r2_ack) ack2_seen++;
                act = o_req | o_ack;
                if (prev_act && act)
                    chk("o_data_hold", 64'(o_data), 64'(prev_data));
                prev_act  = act;
                prev_data = o_data;
            end
        end
    end

    // Sink with random 0-3 cycle ack delay
    initial begin
        int d;
        int n;
        forever begin
            @(posedge clk); #1;
            if (sink_en && !rst && o_req && !o_ack) begin
                take();
                d = $urandom_range(0, 3);
                repeat (d) begin @(posedge clk); #1; end
                o_ack = 1'b1;
                n = 0;
                while (o_req && n < 100) begin
                    @(posedge clk); #1; n++;
                end
                chk("o_req_drop", 64'(o_req), 64'd0);
                o_ack = 1'b0;
            end
        end
    end

    initial begin
        int base;
        logic [W-1:0] cap;
        logic [W-1:0] d1;
        logic [W-1:0] d2;

        do_reset();
        sink_en = 1'b1;

        ack1_seen = 0; ack2_seen = 0;
        send(1, 33'h5);
        wait_out(1);
        chk("t1_out", 64'(out_log[0]), 64'h5);
        chk("t1_r1_ack", 64'(ack1_seen != 0), 64'd1);
        chk("t1_r2_ack", 64'(ack2_seen), 64'd0);

        ack1_seen = 0; ack2_seen = 0;
        send(2, 33'hC);
        wait_out(2);
        chk("t2_out", 64'(out_log[1]), 64'hC);
        chk("t2_r1_ack", 64'(ack1_seen), 64'd0);

        do_reset();
        base = out_log.size();
        fork
            send(1, 33'h3);
            send(2, 33'h9);
        join
        wait_out(base + 2);
        chk("tie1_first", 64'(out_log[base]), 64'h3);
        chk("tie1_second", 64'(out_log[base+1]), 64'h9);

        base = out_log.size();
        fork
            send(1, 33'h7);
            send(2, 33'h4);
        join
        wait_out(base + 2);
        chk("tie2_first", 64'(out_log[base]), 64'h7);
        chk("tie2_second", 64'(out_log[base+1]), 64'h4);

        base = out_log.size();
        for (int i = 0; i < 30; i++) begin
            d1 = {24'd0, 5'(i), 4'($urandom_range(0, 15))};
            d2 = {1'b1, 23'd0, 5'(i), 4'($urandom_range(0, 15))};
            fork
                send(1, d1);
                send(2, d2);
            join
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_out(base + 60);
        chk("rand_count", 64'(out_log.size() - base), 64'd60);
        chk("rand_drained", 64'(q1.size() + q2.size()), 64'd0);

        sink_en = 1'b0;
        base = out_log.size();
        fork
            send(1, 33'h11);
            send(2, 33'h22);
            begin
                wait_oreq();
                cap = o_data;
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk); #1;
                    chk("stall_o_req", 64'(o_req), 64'd1);
                    chk("stall_o_data", 64'(o_data), 64'(cap));
                    chk("stall_acks", 64'({r1_ack, r2_ack}), 64'd0);
                end
                sink_en = 1'b1;
            end
        join
        wait_out(base + 2);
        chk("stall_count", 64'(out_log.size() - base), 64'd2);

        sink_en = 1'b0;
        send(1, 33'h1AB);
        wait_oreq();
        #2 rst = 1'b1;
        #1;
        chk("arst_o_req", 64'(o_req), 64'd0);
        chk("arst_acks", 64'({r1_ack, r2_ack}), 64'd0);
        chk("arst_o_data", 64'(o_data), 64'd0);
`ifdef ARB_MERGE_SRC_TAG_EN
        chk("arst_o_src", 64'(o_src), 64'd0);
`endif
        @(posedge clk); #1;
        do_reset();
        sink_en = 1'b1;
        base = out_log.size();
        send(1, 33'h1);
        wait_out(base + 1);
        chk("post_rst_out", 64'(out_log[base]), 64'h1);
        chk("post_rst_drained", 64'(q1.size() + q2.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
